// File: rtl/feature_out_ddr_writer.sv
// Streams the feature-out tile of each channel in a group to DDR as wide beats.
// Each channel's tile is snapshotted in one LOAD cycle and then sent beat by beat.
module feature_out_ddr_writer #(
  parameter int FW = 16,
  parameter int US = 7,
  parameter int DW = 512,
  parameter int MS = 32
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    start_i,
  input  logic [31:0]             base_addr_i,
  input  logic [5:0]              ch_num_i,
  output logic [4:0]              ch_idx_o,
  input  logic [4*US*US*FW-1:0]   tile_data_i,
  output logic                    ddr_wr_valid_o,
  input  logic                    ddr_wr_ready_i,
  output logic [DW-1:0]           ddr_wr_data_o,
  output logic [31:0]             ddr_wr_addr_o,
  output logic [5:0]              data_valid_num_o,
  output logic                    ddr_wr_last_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int TE = 4 * US * US;
  localparam int EB = DW / FW;
  localparam int BT = (TE + EB - 1) / EB;
  localparam int LV = TE - (BT - 1) * EB;
  localparam int BW = (BT > 1) ? $clog2(BT) : 1;
  localparam int TW = TE * FW;
  localparam int PW = BT * DW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]    r_state;
  logic [31:0]   r_addr;
  logic [5:0]    r_chNum;
  logic [4:0]    r_ch;
  logic [BW-1:0] r_beat;
  logic [TW-1:0] r_tile;

  logic [5:0]    w_chNumClamp;
  logic          w_send;
  logic          w_lastBeat;
  logic          w_moreCh;
  logic [PW-1:0] w_tilePad;
  logic [DW-1:0] w_beatData;

  assign w_chNumClamp = (ch_num_i > 6'(MS)) ? 6'(MS) : ch_num_i;
  assign w_send       = (r_state == S_SEND);
  assign w_lastBeat   = (r_beat == BW'(BT - 1));
  assign w_moreCh     = (({1'b0, r_ch} + 6'd1) < r_chNum);

  // Zero-extend the tile to a whole number of beats so the tail of the last beat reads zero.
  always_comb begin
    w_tilePad = '0;
    w_tilePad[TW-1:0] = r_tile;
  end

  always_comb begin
    w_beatData = '0;
    for (int b = 0; b < BT; b++) begin
      if (r_beat == BW'(b)) begin
        w_beatData = w_tilePad[b*DW +: DW];
      end
    end
  end

  // Outputs are decoded from registers only, so ready never reaches them combinationally.
  assign ddr_wr_valid_o   = w_send;
  assign ddr_wr_data_o    = w_send ? w_beatData : '0;
  assign ddr_wr_addr_o    = w_send ? r_addr : '0;
  assign data_valid_num_o = w_send ? (w_lastBeat ? 6'(LV) : 6'(EB)) : '0;
  assign ddr_wr_last_o    = w_send & w_lastBeat;
  assign busy_o           = (r_state == S_LOAD) || w_send;
  assign done_o           = (r_state == S_DONE);
  assign ch_idx_o         = r_ch;

  // The address register simply counts accepted beats, since channel tiles are packed back to back.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_chNum <= '0;
      r_ch    <= '0;
      r_beat  <= '0;
      r_tile  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_addr  <= base_addr_i;
            r_chNum <= w_chNumClamp;
            r_beat  <= '0;
            if (w_chNumClamp != 6'd0) begin
              r_ch    <= '0;
              r_state <= S_LOAD;
            end else begin
              r_state <= S_DONE;
            end
          end
        end
        S_LOAD: begin
          r_tile  <= tile_data_i;
          r_state <= S_SEND;
        end
        S_SEND: begin
          if (ddr_wr_ready_i) begin
            r_addr <= r_addr + 32'd1;
            if (w_lastBeat) begin
              r_beat <= '0;
              if (w_moreCh) begin
                r_ch    <= r_ch + 5'd1;
                r_state <= S_LOAD;
              end else begin
                r_state <= S_DONE;
              end
            end else begin
              r_beat <= r_beat + BW'(1);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_feature_out_ddr_writer.sv
// Randomized bench for feature_out_ddr_writer: expected beats are queued per group and
// matched by an independent monitor whenever the writer presents a beat.
module tb_feature_out_ddr_writer;

  localparam int FW = 16;
  localparam int US = 7;
  localparam int DW = 512;
  localparam int MS = 32;
  localparam int TE = 4 * US * US;
  localparam int EB = DW / FW;
  localparam int BT = (TE + EB - 1) / EB;
  localparam int LV = TE - (BT - 1) * EB;

  typedef struct {
    logic [DW-1:0] data;
    logic [31:0]   addr;
    logic [5:0]    num;
    logic          last;
    logic [4:0]    ch;
  } beat_t;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            start_i = 1'b0;
  logic [31:0]     base_addr_i = '0;
  logic [5:0]      ch_num_i = '0;
  logic [4:0]      ch_idx_o;
  logic [TE*FW-1:0] tile_data_i;
  logic            ddr_wr_valid_o;
  logic            ddr_wr_ready_i = 1'b1;
  logic [DW-1:0]   ddr_wr_data_o;
  logic [31:0]     ddr_wr_addr_o;
  logic [5:0]      data_valid_num_o;
  logic            ddr_wr_last_o;
  logic            busy_o;
  logic            done_o;

  logic [TE*FW-1:0] tiles [MS];
  beat_t sbq[$];
  int    nChecks = 0;
  int    nFails = 0;
  int    cyc = 0;
  int    lastFinalCyc = -10;
  int    expValidNext = 2;
  bit    readyRnd = 1'b0;

  feature_out_ddr_writer #(.FW(FW), .US(US), .DW(DW), .MS(MS)) dut (
    .clk_i            (clk),
    .rstn_i           (rstn),
    .start_i          (start_i),
    .base_addr_i      (base_addr_i),
    .ch_num_i         (ch_num_i),
    .ch_idx_o         (ch_idx_o),
    .tile_data_i      (tile_data_i),
    .ddr_wr_valid_o   (ddr_wr_valid_o),
    .ddr_wr_ready_i   (ddr_wr_ready_i),
    .ddr_wr_data_o    (ddr_wr_data_o),
    .ddr_wr_addr_o    (ddr_wr_addr_o),
    .data_valid_num_o (data_valid_num_o),
    .ddr_wr_last_o    (ddr_wr_last_o),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // The buffer mux: the tile presented is whatever channel the writer selects.
  assign tile_data_i = tiles[ch_idx_o];

  always @(posedge clk) begin
    #1;
    ddr_wr_ready_i = readyRnd ? ($urandom_range(0, 99) < 55) : 1'b1;
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every presented beat must equal the queue head; it is consumed only when accepted.
  always @(negedge clk) begin
    if (rstn) begin
      if (expValidNext != 2) begin
        checkOutput("validSequence", DW'(ddr_wr_valid_o), DW'(expValidNext));
        expValidNext = 2;
      end
      if (ddr_wr_valid_o) begin
        if (sbq.size() == 0) begin
          checkOutput("unexpectedBeat", DW'(ddr_wr_addr_o), DW'(0));
        end else begin
          checkOutput("beatAddr", DW'(ddr_wr_addr_o), DW'(sbq[0].addr));
          checkOutput("beatData", ddr_wr_data_o, sbq[0].data);
          checkOutput("beatNum", DW'(data_valid_num_o), DW'(sbq[0].num));
          checkOutput("beatLast", DW'(ddr_wr_last_o), DW'(sbq[0].last));
          checkOutput("beatChIdx", DW'(ch_idx_o), DW'(sbq[0].ch));
          if (ddr_wr_ready_i) begin
            expValidNext = sbq[0].last ? 0 : 1;
            void'(sbq.pop_front());
            if (expValidNext == 0 && sbq.size() == 0) lastFinalCyc = cyc;
          end
        end
      end
      if (done_o) begin
        checkOutput("doneQueueEmpty", DW'(sbq.size()), DW'(0));
        checkOutput("doneBusyLow", DW'(busy_o), DW'(0));
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Valid"}, DW'(ddr_wr_valid_o), DW'(0));
    checkOutput({tag, "Busy"}, DW'(busy_o), DW'(0));
    checkOutput({tag, "Done"}, DW'(done_o), DW'(0));
    checkOutput({tag, "Last"}, DW'(ddr_wr_last_o), DW'(0));
    checkOutput({tag, "ChIdx"}, DW'(ch_idx_o), DW'(0));
    checkOutput({tag, "Addr"}, DW'(ddr_wr_addr_o), DW'(0));
    checkOutput({tag, "Data"}, ddr_wr_data_o, DW'(0));
    checkOutput({tag, "Num"}, DW'(data_valid_num_o), DW'(0));
  endtask

  // Reference: channel c occupies BT consecutive words from base + c*BT, elements in order.
  task automatic applyStimulus(input logic [31:0] base, input int chn, input bit rnd,
                               input bit spurious, input bit rstMid);
    int eff;
    int doneCyc;
    bit seen;
    beat_t it;
    eff = (chn > MS) ? MS : chn;
    for (int c = 0; c < eff; c++)
      for (int e = 0; e < TE; e++) tiles[c][e*FW +: FW] = FW'($urandom);
    for (int c = 0; c < eff; c++) begin
      for (int b = 0; b < BT; b++) begin
        it.data = '0;
        for (int k = 0; k < EB; k++) begin
          if (b * EB + k < TE) it.data[k*FW +: FW] = tiles[c][(b*EB+k)*FW +: FW];
        end
        it.addr = base + 32'(c * BT + b);
        it.num  = (b == BT - 1) ? 6'(LV) : 6'(EB);
        it.last = (b == BT - 1);
        it.ch   = 5'(c);
        sbq.push_back(it);
      end
    end
    readyRnd = rnd;
    @(posedge clk); #1;
    start_i = 1'b1; base_addr_i = base; ch_num_i = 6'(chn);
    @(posedge clk); #1;
    start_i = 1'b0; base_addr_i = $urandom; ch_num_i = 6'($urandom);
    @(negedge clk);
    if (eff == 0) begin
      checkOutput("zeroChDone", DW'(done_o), DW'(1));
      checkOutput("zeroChValid", DW'(ddr_wr_valid_o), DW'(0));
      @(negedge clk);
      checkOutput("zeroChDoneWidth", DW'(done_o), DW'(0));
      return;
    end
    checkOutput("loadBusy", DW'(busy_o), DW'(1));
    checkOutput("loadValid", DW'(ddr_wr_valid_o), DW'(0));
    checkOutput("loadChIdx", DW'(ch_idx_o), DW'(0));
    @(negedge clk);
    checkOutput("firstBeatLatency", DW'(ddr_wr_valid_o), DW'(1));
    if (spurious) begin
      @(posedge clk); #1;
      start_i = 1'b1; base_addr_i = 32'hDEAD0000; ch_num_i = 6'd5;
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    if (rstMid) begin
      seen = 1'b0;
      for (int k = 0; k < 500 && !seen; k++) begin
        @(negedge clk);
        if (ddr_wr_valid_o && ch_idx_o == 5'd1 && ddr_wr_addr_o == base + 32'(BT + 4)) seen = 1'b1;
      end
      checkOutput("resetTrigger", DW'(seen), DW'(1));
      #1 rstn = 1'b0;
      @(negedge clk);
      checkAllZero("midReset");
      @(posedge clk); #1;
      rstn = 1'b1;
      sbq.delete();
      expValidNext = 2;
      return;
    end
    seen = 1'b0;
    doneCyc = 0;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(negedge clk);
      if (done_o) begin
        seen = 1'b1;
        doneCyc = cyc;
      end
    end
    checkOutput("doneSeen", DW'(seen), DW'(1));
    if (seen) checkOutput("doneCycle", DW'(doneCyc), DW'(lastFinalCyc + 1));
    @(negedge clk);
    checkOutput("doneWidth", DW'(done_o), DW'(0));
    checkOutput("idleBusy", DW'(busy_o), DW'(0));
  endtask

  initial begin
    for (int c = 0; c < MS; c++) tiles[c] = '0;
    rstn = 1'b0;
    start_i = 1'b1;
    base_addr_i = 32'h1234;
    ch_num_i = 6'd3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk); #1;
    rstn = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    checkOutput("startInResetIgnored", DW'(busy_o), DW'(0));

    applyStimulus(32'h1000, 1, 1'b0, 1'b0, 1'b0);
    applyStimulus($urandom, 3, 1'b0, 1'b0, 1'b0);
    applyStimulus($urandom, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(32'hFFFFFFFE, 1, 1'b0, 1'b0, 1'b0);
    applyStimulus($urandom, 2, 1'b1, 1'b1, 1'b0);
    for (int g = 0; g < 6; g++) applyStimulus($urandom, $urandom_range(1, 5), 1'b1, 1'b0, 1'b0);
    applyStimulus($urandom, 40, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h2000, 3, 1'b0, 1'b0, 1'b1);
    applyStimulus(32'h1000, 1, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
